gelato_l1_icache: RTL and testbench

// - Responder end of the L1 I-cache interface: serves single-word fetch requests from the

---
 rtl/gelato_types_pkg.sv | 25 ++
 rtl/gelato_icache_data_ram.sv | 31 +++
 rtl/gelato_l1_icache.sv | 161 ++++++++++++++++
 tb/tb_gelato_l1_icache.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_types_pkg.sv
// Shared types for the gelato L1 instruction cache: address-field widths,
// field types and the controller state encoding.
package gelato_types;

  localparam int ICACHE_ADDR_W    = 32;
  localparam int ICACHE_DATA_W    = 32;
  localparam int ICACHE_NUM_LINES = 64;
  localparam int ICACHE_WPL       = 4;
  localparam int ICACHE_OFFSET_W  = $clog2(ICACHE_WPL);
  localparam int ICACHE_INDEX_W   = $clog2(ICACHE_NUM_LINES);
  localparam int ICACHE_TAG_W     = ICACHE_ADDR_W - ICACHE_INDEX_W - ICACHE_OFFSET_W - 2;

  typedef logic [ICACHE_TAG_W-1:0]    icache_tag_t;
  typedef logic [ICACHE_INDEX_W-1:0]  icache_index_t;
  typedef logic [ICACHE_OFFSET_W-1:0] icache_offset_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_MISS_REQ  = 3'd2,
    ST_MISS_RESP = 3'd3,
    ST_RESPOND   = 3'd4
  } icache_state_t;

endpackage

// File: rtl/gelato_icache_data_ram.sv
// Instruction data store: synchronous single-read single-write array.
// A same-cycle write to the read address returns the old word.
module gelato_icache_data_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gelato_l1_icache.sv
// Direct-mapped, blocking, read-only L1 instruction cache. Serves one word per
// fetch request and refills a whole line from memory on a miss.
module gelato_l1_icache
  import gelato_types::*;
#(
  parameter int ADDR_W         = ICACHE_ADDR_W,
  parameter int DATA_W         = ICACHE_DATA_W,
  parameter int NUM_LINES      = ICACHE_NUM_LINES,
  parameter int WORDS_PER_LINE = ICACHE_WPL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic [DATA_W-1:0] req_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 2;
  localparam int RAM_AW = IDX_W + OFF_W;

  icache_state_t     state_q;
  logic [ADDR_W-1:2] addr_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q [NUM_LINES];
  logic [OFF_W-1:0]  beat_cnt_q;
  logic              flush_pend_q;
  logic              req_ready_q;
  logic [DATA_W-1:0] req_data_q;
  logic              mem_req_valid_q;
  logic [ADDR_W-1:0] mem_req_addr_q;

  logic [OFF_W-1:0]  cur_off;
  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]  cur_tag;
  logic              hit;
  logic              last_beat;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [RAM_AW-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_byte_bits;

  assign cur_off   = addr_q[OFF_W+1:2];
  assign cur_idx   = addr_q[OFF_W+IDX_W+1:OFF_W+2];
  assign cur_tag   = addr_q[ADDR_W-1:OFF_W+IDX_W+2];
  assign hit       = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign last_beat = (beat_cnt_q == OFF_W'(WORDS_PER_LINE - 1));
  assign unused_byte_bits = ^req_addr[1:0];

  // The lookup read is issued while still in IDLE so the word is ready in LOOKUP.
  assign ram_raddr = (state_q == ST_IDLE) ? req_addr[OFF_W+IDX_W+1:2] : {cur_idx, cur_off};
  assign ram_waddr = {cur_idx, beat_cnt_q};
  assign ram_we    = (state_q == ST_MISS_RESP) && mem_resp_valid;

  gelato_icache_data_ram #(
    .DEPTH  (NUM_LINES * WORDS_PER_LINE),
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_data_ram (
    .clk_i   (clk),
    .en_i    (rdy),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (mem_resp_data),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rdy && (state_q == ST_MISS_RESP) && mem_resp_valid && last_beat) begin
      tag_q[cur_idx] <= cur_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      valid_q         <= '0;
      beat_cnt_q      <= '0;
      flush_pend_q    <= 1'b0;
      req_ready_q     <= 1'b0;
      req_data_q      <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else if (rdy) begin
      req_ready_q <= 1'b0;
      // A flush seen while busy is remembered and applied once back in IDLE.
      if (flush && (state_q != ST_IDLE)) begin
        flush_pend_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (flush || flush_pend_q) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
          end else if (req_valid) begin
            addr_q  <= req_addr[ADDR_W-1:2];
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            req_data_q  <= ram_rdata;
            req_ready_q <= 1'b1;
            state_q     <= ST_RESPOND;
          end else begin
            mem_req_valid_q <= 1'b1;
            mem_req_addr_q  <= {addr_q[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
            state_q         <= ST_MISS_REQ;
          end
        end
        ST_MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            beat_cnt_q      <= '0;
            state_q         <= ST_MISS_RESP;
          end
        end
        ST_MISS_RESP: begin
          if (mem_resp_valid) begin
            beat_cnt_q <= beat_cnt_q + OFF_W'(1);
            if (beat_cnt_q == cur_off) begin
              req_data_q <= mem_resp_data;
            end
            if (last_beat) begin
              valid_q[cur_idx] <= 1'b1;
              req_ready_q      <= 1'b1;
              state_q          <= ST_RESPOND;
            end
          end
        end
        ST_RESPOND: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign req_data      = req_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;

  // Refill beats are only legal while the cache is enabled.
  assert property (@(posedge clk) disable iff (rst) !rdy |-> !mem_resp_valid);

endmodule

// File: tb/tb_gelato_l1_icache.sv
// Bench for gelato_l1_icache: directed scenarios plus random fetches, checked
// against a tag/valid reference model and a word-addressed backing memory.
module tb_gelato_l1_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic [31:0] req_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [int unsigned];
  bit          mvalid [64];
  int unsigned mtag   [64];

  gelato_l1_icache dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int unsigned w);
    if (!mem.exists(w)) mem[w] = $urandom;
    return mem[w];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endtask

  // One fetch with the bench acting as fetch unit and memory. stall = cycles
  // mem_req_ready is withheld, freeze_at = beat before which rdy drops 3 cycles.
  task automatic fetch(input logic [31:0] a, input int stall, input int freeze_at,
                       input bit flush_during);
    int unsigned idx, tg, line_w;
    bit          miss, saw_mreq, done;
    int          exp_lat, phase, beats, st, fz;
    logic [31:0] line, exp_data;
    idx      = (a >> 4) % 64;
    tg       = a >> 10;
    miss     = !(mvalid[idx] && (mtag[idx] == tg));
    line     = a & ~32'h0000_000F;
    line_w   = line >> 2;
    exp_data = mem_word(a >> 2);
    exp_lat  = miss ? (2 + stall + 4 + ((freeze_at >= 0) ? 3 : 0)) : 1;
    saw_mreq = 1'b0; done = 1'b0; phase = 0; beats = 0; st = 0; fz = 0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (flush_during && c == 1) flush = 1'b1;
      if (req_ready) begin
        chk("latency", c, exp_lat);
        chk("data", req_data, exp_data);
        chk("miss_seen", {31'd0, saw_mreq}, {31'd0, miss});
        done           = 1'b1;
        req_valid      = 1'b0;
        req_addr       = $urandom;
        mem_resp_valid = 1'b0;
        rdy            = 1'b1;
      end else begin
        if (mem_req_valid) begin
          chk(saw_mreq ? "mreq_hold" : "mreq_addr", mem_req_addr, line);
          saw_mreq = 1'b1;
        end
        if (phase == 0) begin
          if (mem_req_valid) begin
            if (st < stall) begin
              st++;
              mem_req_ready = 1'b0;
            end else begin
              mem_req_ready = 1'b1;
              phase = 1;
            end
          end
        end else begin
          if (phase == 1) begin
            mem_req_ready = 1'b0;
            phase = 2;
          end
          if (beats == freeze_at && fz < 3) begin
            if (fz > 0) chk("frozen_mreq", {31'd0, mem_req_valid}, 32'd0);
            rdy            = 1'b0;
            mem_resp_valid = 1'b0;
            fz++;
          end else begin
            rdy = 1'b1;
            if (beats < 4) begin
              mem_resp_valid = 1'b1;
              mem_resp_data  = mem_word(line_w + beats);
              beats++;
            end else begin
              mem_resp_valid = 1'b0;
            end
          end
        end
      end
    end
    if (!done) begin
      chk("timeout", 32'd0, 32'd1);
      req_valid = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b0; rdy = 1'b1;
    end
    @(negedge clk);
    chk("ready_pulse", {31'd0, req_ready}, 32'd0);
    if (miss) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
    end
    if (flush_during) begin
      @(negedge clk);
      flush = 1'b0;
      model_clear();
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    model_clear();
    for (int i = 0; i < 4; i++) mem[32'h1000 / 4 + i] = 32'h0000_00A0 + i;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_req_data", req_data, 32'd0);
    chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);

    fetch(32'h0000_1008, 0, -1, 1'b0);   // cold miss -> 0xA2
    fetch(32'h0000_1004, 0, -1, 1'b0);   // hit -> 0xA1
    fetch(32'h0000_1400, 0, -1, 1'b0);   // conflict refill
    fetch(32'h0000_1000, 0, -1, 1'b0);   // misses again -> 0xA0
    fetch(32'h0000_1000, 0, -1, 1'b0);   // hit

    // flush pulse in IDLE, then the same line misses
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    fetch(32'h0000_1000, 0, -1, 1'b0);

    // flush held across a refill: request completes, line invalid afterwards
    fetch(32'h0000_2008, 0, -1, 1'b1);
    fetch(32'h0000_2008, 0, -1, 1'b0);

    fetch(32'h0000_3000, 5, -1, 1'b0);   // memory backpressure
    fetch(32'h0000_4004, 1, 2, 1'b0);    // rdy freeze mid-refill

    // reset in the middle of a refill
    begin
      bit got;
      got = 1'b0;
      req_valid = 1'b1;
      req_addr  = 32'h0000_5008;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        got = mem_req_valid;
      end
      chk("rmr_mreq", {31'd0, got}, 32'd1);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(32'h5000 / 4);
      @(negedge clk);
      mem_resp_data  = mem_word(32'h5000 / 4 + 1);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      req_valid      = 1'b0;
      rst            = 1'b1;
      #1;
      chk("rmr_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rmr_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int b = 2; b < 4; b++) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_word(32'h5000 / 4 + b);
        @(negedge clk);
        chk("stray_req_ready", {31'd0, req_ready}, 32'd0);
        chk("stray_mreq", {31'd0, mem_req_valid}, 32'd0);
      end
      mem_resp_valid = 1'b0;
      model_clear();
      fetch(32'h0000_5008, 0, -1, 1'b0);
    end

    // random fetches over a small set of lines to mix hits, misses and conflicts
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int          fr;
      a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
         | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      fr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      fetch(a, int'($urandom_range(0, 3)), fr, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
